alu_core: RTL and testbench
===========================

Name: alu_core

Overview:
- Parameterised integer ALU: width-w operands a, b; operation select op; produces result plus status flags.
- Sits on the CPU datapath between register file and data bus; outputs registered (one-cycle latency) so the datapath can sample them on the next clock edge.
- Width w tracks the system word/data bus width (8 in the current system).

Parameters:
- w, 8, operand/result/data-bus width in bits (w >= 2).
- op_w, 1, width of op select; only ops 0..2^op_w-1 reachable (op_w <= 3).
- status_w, 1, number of status flag bits exported (1..4).

Ports:
- clock  input  1  system clock, rising-edge active.
- reset_n  input  1  asynchronous active-low reset.
- result  output  w  registered operation result.
- status  output  status_w  registered flags; bit i per flag list below, low status_w bits only.
- op  input  op_w  operation select.
- a  input  w  operand A.
- b  input  w  operand B.

Behaviour:
- Reset: reset_n low forces result=0 and status=0 immediately (async), held while low; release synchronous to the next rising clock.
- Every rising clock edge with reset_n high: compute from current op, a, b and register into result/status. Latency exactly 1 cycle; new operation every cycle; no handshake.
- Op encoding (zero-extended op to 3 bits):
  - 0 ADD: a+b mod 2^w.
  - 1 SUB: a-b mod 2^w.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 NOT: ~a (b ignored).
  - 6 SHL: a<<1, zero fill.
  - 7 SHR: a>>1 logical, zero fill.
- Status flags, computed on the same edge as result:
  - bit0 C: ADD carry-out of bit w-1; SUB borrow (1 when a<b unsigned); SHL = old a[w-1]; SHR = old a[0]; logic ops 0.
  - bit1 Z: result==0.
  - bit2 N: result[w-1].
  - bit3 V: signed overflow for ADD/SUB; 0 otherwise.
- Flags with index >= status_w are not exported.
- Arithmetic is done in w+1 bits internally; no saturation, wrap-around modulo 2^w.
- Unreachable or unknown op (X on inputs) has no defined result; synthesizable default branch yields result=0, flags=0.
- Reset asserted mid-operation discards the pending computation; first valid result appears one edge after release.

Decomposition:
- Shared package alu_pkg:
  - op encoding constants: OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_XOR=4, OP_NOT=5, OP_SHL=6, OP_SHR=7.
  - flag index constants: FLAG_C=0, FLAG_Z=1, FLAG_N=2, FLAG_V=3.
- One natural sub-module, alu_comb: purely combinational op/flag evaluation (no clock).
- alu_core wraps alu_comb with the output register stage and reset.

Test Plan:
- reset_n=0 with a=8'hFF, b=8'h01, op=0 -> result=0, status=0 immediately, held across clock edges until release.
- ADD: a=8'h02, b=8'h06, op=0 -> one edge later result=8'h08, status[0]=0.
- ADD carry: a=8'hFF, b=8'h01, op=0 -> result=8'h00, C=1 (status_w=1); Z=1 with status_w=4.
- SUB: a=8'h02, b=8'h06, op=1 -> result=8'hFC, C(borrow)=1; a=8'h06, b=8'h02 -> result=8'h04, C=0.
- op_w=3 sweep with a=8'hA5, b=8'h0F:
  - AND -> 8'h05; OR -> 8'hAF; XOR -> 8'hAA; NOT -> 8'h5A.
  - SHL -> 8'h4A, C=1; SHR -> 8'h52, C=1.
- Back-to-back ops on consecutive edges each appear exactly one cycle later; reset pulse mid-stream clears outputs asynchronously.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: operation encoding and status flag positions.
package alu_pkg;

  // The op select is always interpreted as a 3-bit code after zero-extension.
  localparam int OP_ENC_W = 3;

  // Total number of status flags the ALU can produce.
  localparam int FLAG_W = 4;

  // Operation encoding.
  localparam logic [OP_ENC_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_ENC_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_ENC_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_ENC_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_ENC_W-1:0] OP_XOR = 3'd4;
  localparam logic [OP_ENC_W-1:0] OP_NOT = 3'd5;
  localparam logic [OP_ENC_W-1:0] OP_SHL = 3'd6;
  localparam logic [OP_ENC_W-1:0] OP_SHR = 3'd7;

  // Flag bit positions inside the status vector.
  localparam int FLAG_C = 0;  // carry / borrow / shifted-out bit
  localparam int FLAG_Z = 1;  // result is zero
  localparam int FLAG_N = 2;  // result sign bit
  localparam int FLAG_V = 3;  // signed overflow (ADD/SUB only)

endpackage

// File: rtl/alu_comb.sv
// Purely combinational ALU evaluation: result and all four status flags
// from op, a and b. No clock, no state.
module alu_comb
  import alu_pkg::*;
#(
  parameter int w    = 8,
  parameter int op_w = 1
) (
  input  logic [op_w-1:0]   op,
  input  logic [w-1:0]      a,
  input  logic [w-1:0]      b,
  output logic [w-1:0]      result,
  output logic [FLAG_W-1:0] flags
);

  logic [OP_ENC_W-1:0] op_ext;
  logic [w:0]          sum_ext;
  logic [w:0]          diff_ext;
  logic [w-1:0]        res;
  logic                carry;
  logic                ovf;
  logic                op_known;

  // Evaluate the selected operation; arithmetic is done one bit wider so the
  // top bit is the carry-out (ADD) or borrow (SUB).
  always_comb begin
    op_ext   = OP_ENC_W'(op);
    sum_ext  = {1'b0, a} + {1'b0, b};
    diff_ext = {1'b0, a} - {1'b0, b};
    res      = '0;
    carry    = 1'b0;
    ovf      = 1'b0;
    op_known = 1'b1;
    case (op_ext)
      OP_ADD: begin
        res   = sum_ext[w-1:0];
        carry = sum_ext[w];
        // Overflow: operands share a sign and the result sign differs.
        ovf   = (a[w-1] == b[w-1]) && (sum_ext[w-1] != a[w-1]);
      end
      OP_SUB: begin
        res   = diff_ext[w-1:0];
        carry = diff_ext[w];
        // Overflow: operand signs differ and the result sign differs from a.
        ovf   = (a[w-1] != b[w-1]) && (diff_ext[w-1] != a[w-1]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOT: res = ~a;
      OP_SHL: begin
        res   = {a[w-2:0], 1'b0};
        carry = a[w-1];
      end
      OP_SHR: begin
        res   = {1'b0, a[w-1:1]};
        carry = a[0];
      end
      default: begin
        // Only reachable with X/Z on op: everything, including Z, reads 0.
        res      = '0;
        carry    = 1'b0;
        ovf      = 1'b0;
        op_known = 1'b0;
      end
    endcase
  end

  // Pack the flags; Z is qualified so the unknown-op branch yields all zeros.
  always_comb begin
    result         = res;
    flags          = '0;
    flags[FLAG_C]  = carry;
    flags[FLAG_Z]  = op_known && (res == '0);
    flags[FLAG_N]  = res[w-1];
    flags[FLAG_V]  = ovf;
  end

endmodule

// File: rtl/alu_core.sv
// Registered integer ALU. Inputs are sampled every rising clock edge and the
// result/status appear one cycle later. There is no handshake: a new
// operation is accepted on every edge while reset_n is high, and outputs are
// always considered valid one edge after the inputs were presented.
module alu_core
  import alu_pkg::*;
#(
  parameter int w        = 8,
  parameter int op_w     = 1,
  parameter int status_w = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  output logic [w-1:0]        result,
  output logic [status_w-1:0] status,
  input  logic [op_w-1:0]     op,
  input  logic [w-1:0]        a,
  input  logic [w-1:0]        b
);

  logic [w-1:0]        comb_result;
  logic [FLAG_W-1:0]   comb_flags;
  logic [w-1:0]        result_d;
  logic [w-1:0]        result_q;
  logic [status_w-1:0] status_d;
  logic [status_w-1:0] status_q;
  logic                unused_flags;

  alu_comb #(
    .w    (w),
    .op_w (op_w)
  ) u_alu_comb (
    .op     (op),
    .a      (a),
    .b      (b),
    .result (comb_result),
    .flags  (comb_flags)
  );

  // Flags above status_w are computed but not exported.
  assign unused_flags = ^comb_flags;

  // Next-state for the output register: only the low status_w flags are kept.
  always_comb begin
    result_d = comb_result;
    status_d = comb_flags[status_w-1:0];
  end

  // Output register stage; async reset clears outputs immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      result_q <= '0;
      status_q <= '0;
    end else begin
      result_q <= result_d;
      status_q <= status_d;
    end
  end

  assign result = result_q;
  assign status = status_q;

endmodule

// File: tb/tb_alu_core.sv
// Directed testbench for alu_core: driver pushes hand-computed expectations
// into a queue, a monitor pops and compares one cycle after issue.
module tb_alu_core;

  localparam int W  = 8;
  localparam int OW = 3;
  localparam int SW = 4;
  localparam int EW = W + SW;

  logic          clock;
  logic          reset_n;
  logic [W-1:0]  result;
  logic [SW-1:0] status;
  logic [OW-1:0] op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;

  logic [EW-1:0] exp_q[$];
  int            checks;
  int            errors;

  alu_core #(
    .w        (W),
    .op_w     (OW),
    .status_w (SW)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .result  (result),
    .status  (status),
    .op      (op),
    .a       (a),
    .b       (b)
  );

  // Clock and reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Driver: present one op just after a rising edge and queue its expectation.
  task automatic drive_op(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic [W-1:0] er, input logic [SW-1:0] es);
    @(posedge clock);
    #2;
    op = o;
    a  = va;
    b  = vb;
    exp_q.push_back({er, es});
  endtask

  // Wait (bounded) until the monitor has consumed every queued expectation.
  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor / scoreboard: an entry queued before a rising edge is due at the
  // following falling edge.
  initial begin
    logic          due;
    logic [EW-1:0] e;
    forever begin
      @(posedge clock);
      due = (exp_q.size() != 0);
      @(negedge clock);
      if (due && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("result", result, e[EW-1:SW]);
        check("status", W'(status), W'(e[SW-1:0]));
      end
    end
  end

  // Stimulus
  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    op      = 3'd0;
    a       = 8'hFF;
    b       = 8'h01;
    #1;
    check("reset_result_t0", result, 8'h00);
    check("reset_status_t0", W'(status), 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check("reset_hold_result", result, 8'h00);
      check("reset_hold_status", W'(status), 8'h00);
    end
    @(negedge clock);
    reset_n = 1'b1;

    // Back-to-back directed vectors (status = {V,N,Z,C})
    drive_op(3'd0, 8'h02, 8'h06, 8'h08, 4'b0000);  // ADD
    drive_op(3'd0, 8'hFF, 8'h01, 8'h00, 4'b0011);  // ADD carry, zero
    drive_op(3'd1, 8'h02, 8'h06, 8'hFC, 4'b0101);  // SUB borrow
    drive_op(3'd1, 8'h06, 8'h02, 8'h04, 4'b0000);  // SUB
    drive_op(3'd2, 8'hA5, 8'h0F, 8'h05, 4'b0000);  // AND
    drive_op(3'd3, 8'hA5, 8'h0F, 8'hAF, 4'b0100);  // OR
    drive_op(3'd4, 8'hA5, 8'h0F, 8'hAA, 4'b0100);  // XOR
    drive_op(3'd5, 8'hA5, 8'h0F, 8'h5A, 4'b0000);  // NOT
    drive_op(3'd6, 8'hA5, 8'h0F, 8'h4A, 4'b0001);  // SHL
    drive_op(3'd7, 8'hA5, 8'h0F, 8'h52, 4'b0001);  // SHR
    drive_op(3'd0, 8'h7F, 8'h01, 8'h80, 4'b1100);  // ADD signed overflow
    drive_op(3'd0, 8'h80, 8'h80, 8'h00, 4'b1011);  // ADD neg overflow, carry
    drive_op(3'd1, 8'h80, 8'h01, 8'h7F, 4'b1000);  // SUB signed overflow
    drive_op(3'd1, 8'h05, 8'h05, 8'h00, 4'b0010);  // SUB to zero
    drive_op(3'd2, 8'h0F, 8'hF0, 8'h00, 4'b0010);  // AND to zero
    drive_op(3'd7, 8'h01, 8'h00, 8'h00, 4'b0011);  // SHR out last bit
    drive_op(3'd6, 8'h80, 8'h00, 8'h00, 4'b0011);  // SHL out top bit
    drive_op(3'd5, 8'h00, 8'h33, 8'hFF, 4'b0100);  // NOT ignores b
    drain();

    // Mid-stream reset: pending op is discarded, outputs clear at once.
    drive_op(3'd0, 8'h10, 8'h20, 8'h30, 4'b0000);
    drain();
    drive_op(3'd3, 8'h81, 8'h00, 8'h81, 4'b0100);
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("midreset_result", result, 8'h00);
    check("midreset_status", W'(status), 8'h00);
    @(posedge clock);
    #1;
    check("midreset_hold_result", result, 8'h00);
    check("midreset_hold_status", W'(status), 8'h00);
    @(negedge clock);
    reset_n = 1'b1;
    drive_op(3'd1, 8'h00, 8'h01, 8'hFF, 4'b0101);  // SUB 0-1 after release
    drive_op(3'd4, 8'h3C, 8'h3C, 8'h00, 4'b0010);  // XOR to zero
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
